// File: rtl/cla_pkg.sv
// Shared types and constants for the CLA datapath blocks.
// Holds the divider FSM encoding, operand width and iteration counter type.
package cla_pkg;

  localparam int WIDTH = 4;
  localparam int ITERS = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  typedef logic [$clog2(ITERS)-1:0] cnt_t;

  localparam cnt_t LAST_ITER = cnt_t'(ITERS - 1);

endpackage

// File: rtl/CLA_4_bit.sv
// 4-bit carry-lookahead adder: sum = a + b + c_in, carries from generate/propagate terms.
// Purely combinational, zero latency, no flow control.
// Shared by the registered adder wrapper and the restoring divider.
module CLA_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum   = p ^ c[3:0];
  assign c_out = c[4];

endmodule

// File: rtl/cla_restoring_divider_4bit.sv
// 4-bit unsigned restoring divider; each step is a CLA trial subtraction (S + ~M + 1).
// Latency: start accepted at edge N, results and a one-cycle done after edge N+4.
// Backpressure: none; start is ignored while busy, so the caller must wait for done.
module cla_restoring_divider_4bit
  import cla_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_t           state;
  cnt_t             cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic             dbz_pending;

  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] diff;
  logic             c;
  logic             ge;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] q_next;

  assign s = {a_reg, q_reg[WIDTH-1]};

  CLA_4_bit u_cla (
    .a     (s[WIDTH-1:0]),
    .b     (~m_reg),
    .c_in  (1'b1),
    .sum   (diff),
    .c_out (c)
  );

  // When ge=0 the shifted value had S[4]=0, so A never needs a fifth bit.
  assign ge     = s[WIDTH] | c;
  assign a_next = ge ? diff : s[WIDTH-1:0];
  assign q_next = {q_reg[WIDTH-2:0], ge};

  assign busy = (state == CALC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      a_reg       <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      dbz_pending <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg       <= '0;
            q_reg       <= dividend;
            m_reg       <= divisor;
            cnt         <= '0;
            dbz_pending <= (divisor == '0);
            state       <= CALC;
          end
        end
        CALC: begin
          a_reg <= a_next;
          q_reg <= q_next;
          cnt   <= cnt + cnt_t'(1);
          if (cnt == LAST_ITER) begin
            quotient    <= q_next;
            remainder   <= a_next;
            div_by_zero <= dbz_pending;
            done        <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_restoring_divider_4bit.sv
// Bench for the restoring divider: cycle-level reference model plus directed and random stimulus.
module tb_cla_restoring_divider_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  cla_restoring_divider_4bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation occupies 4 cycles after acceptance and then
  // publishes plain-arithmetic quotient/remainder for one done cycle.
  int         m_rem = 0;
  logic [3:0] m_q = '0, m_r = '0, m_pq = '0, m_pr = '0;
  logic       m_dbz = 1'b0, m_pdbz = 1'b0, m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_rem = 0; m_q = '0; m_r = '0; m_dbz = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_q = m_pq; m_r = m_pr; m_dbz = m_pdbz; m_done = 1'b1;
        end
      end else if (start) begin
        m_rem = 4;
        if (divisor == 0) begin
          m_pq = 4'hF; m_pr = dividend; m_pdbz = 1'b1;
        end else begin
          m_pq = dividend / divisor; m_pr = dividend % divisor; m_pdbz = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc busy", busy, (m_rem > 0));
      chk("cyc done", done, m_done);
      chk("cyc quotient", quotient, m_q);
      chk("cyc remainder", remainder, m_r);
      chk("cyc div_by_zero", div_by_zero, m_dbz);
    end
  end

  // Called at a negedge; start is sampled at the next posedge. Returns at the done negedge.
  task automatic run_op(input string nm, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic [3:0] er, input logic edbz);
    int lat;
    int bcnt;
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = 4'($urandom); divisor = 4'($urandom);
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 10) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 8'(lat), 8'd4);
    chk({nm, " busy cycles"}, 8'(bcnt), 8'd4);
    chk({nm, " quotient"}, quotient, eq);
    chk({nm, " remainder"}, remainder, er);
    chk({nm, " div_by_zero"}, div_by_zero, edbz);
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset quotient", quotient, 8'd0);
    chk("reset remainder", remainder, 8'd0);
    chk("reset busy", busy, 8'd0);
    chk("reset done", done, 8'd0);
    chk("reset div_by_zero", div_by_zero, 8'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("13/3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    @(negedge clk);
    run_op("7/0", 4'd7, 4'd0, 4'hF, 4'd7, 1'b1);
    @(negedge clk);
    run_op("2/9", 4'd2, 4'd9, 4'd0, 4'd2, 1'b0);
    @(negedge clk);
    run_op("15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    @(negedge clk);

    // start while busy must be ignored
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("12/5 done seen", done, 8'd1);
    chk("12/5 quotient", quotient, 8'd2);
    chk("12/5 remainder", remainder, 8'd2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("12/5 no second done", done, 8'd0);
    end

    // reset during step 2 of 14/3
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort quotient", quotient, 8'd0);
    chk("abort remainder", remainder, 8'd0);
    chk("abort busy", busy, 8'd0);
    chk("abort done", done, 8'd0);
    chk("abort div_by_zero", div_by_zero, 8'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort no done", done, 8'd0);
    end
    run_op("14/3 after abort", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0);
    @(negedge clk);

    // back-to-back: second start issued in the done cycle of the first
    run_op("b2b 11/2", 4'd11, 4'd2, 4'd5, 4'd1, 1'b0);
    run_op("b2b 8/8", 4'd8, 4'd8, 4'd1, 4'd0, 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0)
          run_op("sweep", 4'(a), 4'(b), 4'hF, 4'(a), 1'b1);
        else
          run_op("sweep", 4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0);
      end
    end

    // random traffic with occasional resets, checked by the per-cycle model
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      start    = 1'($urandom);
      dividend = 4'($urandom);
      divisor  = 4'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    rst = 1'b0;
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cla_restoring_divider_4bit.md
# cla_restoring_divider_4bit

Sequential 4-bit unsigned restoring divider that runs the inverse of the CLA adder path: each iteration is a trial subtraction through a `CLA_4_bit` instance wired as a subtractor, computed as a + ~b + 1. It sits beside the registered CLA adder wrapper in the ALU datapath. It accepts one operand pair per start pulse and returns quotient and remainder after a fixed latency, with a busy/done handshake.

## Interface
- WIDTH, 4, operand/result width (fixed; CLA_4_bit is 4 bits)
- ITERS, 4, iteration count (= WIDTH)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only when busy=0
- dividend  in  4  unsigned dividend, sampled with start
- divisor  in  4  unsigned divisor, sampled with start
- quotient  out  4  registered quotient; held until next completion
- remainder  out  4  registered remainder; held until next completion
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when quotient/remainder update
- div_by_zero  out  1  registered with the results; high iff the sampled divisor was 0

## Operation
- FSM states: IDLE, CALC.
- IDLE with start=1 at an edge:
  - load A=5'b0, Q=dividend, M=divisor, cnt=0;
  - latch dbz_pending=(divisor==0);
  - go to CALC, busy=1.
- CALC, each edge: one restoring step.
  - S = {A[3:0], Q[3]} (5 bits).
  - CLA computes S[3:0] + ~M + 1 with carry-in 1, giving diff[3:0] and c.
  - ge = S[4] | c.
  - If ge=1: A = {1'b0, diff}, Q = {Q[2:0], 1'b1}.
  - If ge=0: A = S, Q = {Q[2:0], 1'b0}.
  - cnt increments.
- On the edge that completes step 4 (cnt==3):
  - quotient = new Q, remainder = new A[3:0], div_by_zero = dbz_pending;
  - done=1, busy=0, state goes to IDLE.
- Divide by zero: no special path. The algorithm yields quotient=4'hF and remainder=dividend; the div_by_zero flag marks it.
- start while busy=1 is ignored; the operands at that edge are not captured.
- Width rule: the partial remainder A is always < M ≤ 15 after each step, so remainder fits in 4 bits. S[4] is the only bit needing 5 bits.

## Timing
- Reset values (any cycle, including mid-CALC):
  - quotient=0, remainder=0, busy=0, done=0, div_by_zero=0;
  - state=IDLE, cnt=0, A/Q/M=0.
- Reset aborts the operation; no done is produced for it.
- Latency: start sampled at edge N → busy=1 after edge N. Steps occur at edges N+1..N+4. After edge N+4: done=1, busy=0, results valid.
- done is high for exactly one cycle and is cleared at edge N+5 unless a new completion occurs.
- Back-to-back: start high during the done cycle is accepted at edge N+5, so throughput is one operation per 5 cycles.
- quotient, remainder and div_by_zero change only on a completion edge or on reset.
- rst and start high on the same edge: rst wins.

## Structure
- Shared package (cla_pkg) holds:
  - the state enum {IDLE, CALC};
  - the WIDTH=4 and ITERS=4 constants;
  - the 2-bit iteration-counter type.
- One sub-module: the existing CLA_4_bit, instantiated once.
  - Operands: a=S[3:0], b=~M, c_in=1'b1.
  - Outputs: sum → diff, c_out → c.
- All remaining logic (FSM, shift registers, output registers) is in the top module.

## Test plan
- 13/3: start=1 for one cycle → 4 cycles later done=1, quotient=4, remainder=1, div_by_zero=0. busy is high for exactly 4 cycles.
- 7/0 → quotient=4'hF, remainder=7, div_by_zero=1, same latency. 2/9 → quotient=0, remainder=2. 15/1 → quotient=15, remainder=0.
- 12/5 in flight, with start pulsed again carrying 9/2 while busy → only the 12/5 result appears (quotient=2, remainder=2); no second done.
- rst asserted during step 2 of 14/3 → the next cycle shows all outputs 0 and state IDLE; no done; a subsequent 14/3 gives quotient=4, remainder=2.
- Back-to-back: 11/2 followed by start during its done cycle with 8/8 → done at cycles N+4 and N+9. Results are quotient=5, remainder=1, then quotient=1, remainder=0.
- Exhaustive sweep of all 256 pairs against the reference model q=a/b, r=a%b (b=0 → q=15, r=a, dbz=1). Check done-pulse width and latency on every pair.
